// File: rtl/npc_trap_pkg.sv
// Shared trap definitions: FSM encoding, mcause values and the machine-mode CSR addresses
// that the CSR file decodes.
package npc_trap_pkg;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StSave     = 2'd1,
        StRedirect = 2'd2,
        StHalt     = 2'd3
    } trap_state_e;

    localparam logic [31:0] CAUSE_ILLEGAL     = 32'd2;
    localparam logic [31:0] CAUSE_BREAKPOINT  = 32'd3;
    localparam logic [31:0] CAUSE_ECALL_M     = 32'd11;
    localparam logic [31:0] CAUSE_IRQ_DEFAULT = 32'h8000_0007;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

endpackage

// File: rtl/trap_ctrl.sv
// Trap sequencer: turns ecall/ebreak/illegal/interrupt into a one-cycle CSR exception write
// followed by a redirect to mtvec; mret redirects straight to mepc.
module trap_ctrl
    import npc_trap_pkg::*;
#(
    parameter int unsigned     XLEN        = 32,
    parameter bit              EBREAK_HALT = 1'b1,
    parameter logic [XLEN-1:0] IRQ_CAUSE   = XLEN'(CAUSE_IRQ_DEFAULT)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic            is_ecall,
    input  logic            is_ebreak,
    input  logic            is_mret,
    input  logic            is_illegal,
    input  logic            irq,
    input  logic            mstatus_mie,
    input  logic [XLEN-1:0] mtvec,
    input  logic [XLEN-1:0] mepc,
    output logic            commit_en,
    output logic            exception,
    output logic [XLEN-1:0] exception_pc,
    output logic [XLEN-1:0] exception_cause,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    input  logic            redirect_ready,
    output logic            halted
);

    trap_state_e     state_q;
    logic            irq_pending_q;
    logic            exception_q;
    logic [XLEN-1:0] exception_pc_q;
    logic [XLEN-1:0] exception_cause_q;
    logic            redirect_valid_q;
    logic [XLEN-1:0] redirect_pc_q;
    logic            halted_q;

    logic idle;
    logic accept;
    logic take_irq;
    logic trap_insn;

    assign idle      = (state_q == StIdle);
    assign accept    = idle & in_valid;
    assign take_irq  = accept & irq_pending_q & mstatus_mie;
    assign trap_insn = is_illegal | is_ecall | is_ebreak | is_mret;

    assign in_ready        = idle;
    // Gate with rst so nothing is committed on a cycle whose state update is discarded.
    assign commit_en       = accept & ~rst & ~take_irq & ~trap_insn;
    assign exception       = exception_q;
    assign exception_pc    = exception_pc_q;
    assign exception_cause = exception_cause_q;
    assign redirect_valid  = redirect_valid_q;
    assign redirect_pc     = redirect_pc_q;
    assign halted          = halted_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= StIdle;
            irq_pending_q     <= 1'b0;
            exception_q       <= 1'b0;
            exception_pc_q    <= '0;
            exception_cause_q <= '0;
            redirect_valid_q  <= 1'b0;
            redirect_pc_q     <= '0;
            halted_q          <= 1'b0;
        end else begin
            // A new request in the same cycle as the take keeps the latch set.
            irq_pending_q <= irq | (irq_pending_q & ~take_irq);

            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        if (take_irq) begin
                            state_q           <= StSave;
                            exception_q       <= 1'b1;
                            exception_pc_q    <= in_pc;
                            exception_cause_q <= IRQ_CAUSE;
                        end else if (is_illegal) begin
                            state_q           <= StSave;
                            exception_q       <= 1'b1;
                            exception_pc_q    <= in_pc;
                            exception_cause_q <= XLEN'(CAUSE_ILLEGAL);
                        end else if (is_ecall) begin
                            state_q           <= StSave;
                            exception_q       <= 1'b1;
                            exception_pc_q    <= in_pc;
                            exception_cause_q <= XLEN'(CAUSE_ECALL_M);
                        end else if (is_ebreak) begin
                            if (EBREAK_HALT) begin
                                state_q  <= StHalt;
                                halted_q <= 1'b1;
                            end else begin
                                state_q           <= StSave;
                                exception_q       <= 1'b1;
                                exception_pc_q    <= in_pc;
                                exception_cause_q <= XLEN'(CAUSE_BREAKPOINT);
                            end
                        end else if (is_mret) begin
                            state_q          <= StRedirect;
                            redirect_valid_q <= 1'b1;
                            redirect_pc_q    <= mepc;
                        end
                    end
                end
                StSave: begin
                    // mtvec is sampled here, after any CSR write that preceded the trap.
                    state_q           <= StRedirect;
                    exception_q       <= 1'b0;
                    exception_pc_q    <= '0;
                    exception_cause_q <= '0;
                    redirect_valid_q  <= 1'b1;
                    redirect_pc_q     <= mtvec;
                end
                StRedirect: begin
                    if (redirect_ready) begin
                        state_q          <= StIdle;
                        redirect_valid_q <= 1'b0;
                        redirect_pc_q    <= '0;
                    end
                end
                StHalt: begin
                    halted_q <= 1'b1;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed plus randomized bench for trap_ctrl; two instances (ebreak halts / ebreak traps)
// share stimulus and are compared against a transaction-level model each cycle.
module tb_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst, in_valid, is_ecall, is_ebreak, is_mret, is_illegal;
    logic        irq, mstatus_mie, redirect_ready;
    logic [31:0] in_pc, mtvec, mepc;

    logic        in_ready_w[2], commit_en_w[2], exception_w[2], redirect_valid_w[2], halted_w[2];
    logic [31:0] exception_pc_w[2], exception_cause_w[2], redirect_pc_w[2];

    int checks = 0;
    int failures = 0;

    // Model: outstanding CSR write beat, outstanding redirect, halt flag, pending interrupt.
    bit          m_exc[2], m_redir[2], m_halt[2], m_pend[2];
    logic [31:0] m_epc[2], m_cause[2], m_rpc[2];
    logic [31:0] irq_cause[2];

    always #5 clk = ~clk;

    trap_ctrl #(
        .XLEN(32), .EBREAK_HALT(1'b1), .IRQ_CAUSE(32'h8000_0007)
    ) dut_h (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[0]), .in_pc(in_pc),
        .is_ecall(is_ecall), .is_ebreak(is_ebreak), .is_mret(is_mret), .is_illegal(is_illegal),
        .irq(irq), .mstatus_mie(mstatus_mie), .mtvec(mtvec), .mepc(mepc),
        .commit_en(commit_en_w[0]), .exception(exception_w[0]),
        .exception_pc(exception_pc_w[0]), .exception_cause(exception_cause_w[0]),
        .redirect_valid(redirect_valid_w[0]), .redirect_pc(redirect_pc_w[0]),
        .redirect_ready(redirect_ready), .halted(halted_w[0])
    );

    trap_ctrl #(
        .XLEN(32), .EBREAK_HALT(1'b0), .IRQ_CAUSE(32'h8000_000B)
    ) dut_t (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[1]), .in_pc(in_pc),
        .is_ecall(is_ecall), .is_ebreak(is_ebreak), .is_mret(is_mret), .is_illegal(is_illegal),
        .irq(irq), .mstatus_mie(mstatus_mie), .mtvec(mtvec), .mepc(mepc),
        .commit_en(commit_en_w[1]), .exception(exception_w[1]),
        .exception_pc(exception_pc_w[1]), .exception_cause(exception_cause_w[1]),
        .redirect_valid(redirect_valid_w[1]), .redirect_pc(redirect_pc_w[1]),
        .redirect_ready(redirect_ready), .halted(halted_w[1])
    );

    task automatic check_eq(input string tag, input int k, input logic [31:0] got,
                            input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s dut%0d t=%0t got=%h exp=%h", tag, k, $time, got, exp);
        end
    endtask

    task automatic model_exc(input int k, input logic [31:0] pc, input logic [31:0] cause);
        m_exc[k]   = 1'b1;
        m_epc[k]   = pc;
        m_cause[k] = cause;
    endtask

    // kind: 0 plain, 1 ecall, 2 ebreak, 3 mret, 4 illegal
    task automatic apply(input bit r, input bit v, input logic [31:0] pc, input int kind,
                         input bit irq_in, input bit mie, input bit rr,
                         input logic [31:0] tv, input logic [31:0] ep);
        @(negedge clk);
        rst = r; in_valid = v; in_pc = pc;
        is_ecall = (kind == 1); is_ebreak = (kind == 2);
        is_mret = (kind == 3); is_illegal = (kind == 4);
        irq = irq_in; mstatus_mie = mie; redirect_ready = rr; mtvec = tv; mepc = ep;
        #1;
        for (int k = 0; k < 2; k++) begin
            bit busy, take, trap;
            busy = m_halt[k] || m_exc[k] || m_redir[k];
            take = !busy && v && m_pend[k] && mie;
            trap = take || (kind != 0);
            check_eq("in_ready", k, 32'(in_ready_w[k]), 32'(!busy));
            check_eq("commit_en", k, 32'(commit_en_w[k]), 32'(!busy && v && !r && !trap));
            check_eq("exception", k, 32'(exception_w[k]), 32'(m_exc[k]));
            check_eq("exception_pc", k, exception_pc_w[k], m_exc[k] ? m_epc[k] : 32'h0);
            check_eq("exception_cause", k, exception_cause_w[k], m_exc[k] ? m_cause[k] : 32'h0);
            check_eq("redirect_valid", k, 32'(redirect_valid_w[k]), 32'(m_redir[k]));
            check_eq("redirect_pc", k, redirect_pc_w[k], m_redir[k] ? m_rpc[k] : 32'h0);
            check_eq("halted", k, 32'(halted_w[k]), 32'(m_halt[k]));

            if (r) begin
                m_exc[k] = 0; m_redir[k] = 0; m_halt[k] = 0; m_pend[k] = 0;
            end else begin
                if (m_exc[k]) begin
                    m_exc[k]   = 0;
                    m_redir[k] = 1;
                    m_rpc[k]   = tv;
                end else if (m_redir[k]) begin
                    if (rr) m_redir[k] = 0;
                end else if (!m_halt[k] && v) begin
                    if (take) model_exc(k, pc, irq_cause[k]);
                    else if (kind == 4) model_exc(k, pc, 32'd2);
                    else if (kind == 1) model_exc(k, pc, 32'd11);
                    else if (kind == 2) begin
                        if (k == 0) m_halt[k] = 1;
                        else model_exc(k, pc, 32'd3);
                    end else if (kind == 3) begin
                        m_redir[k] = 1;
                        m_rpc[k]   = ep;
                    end
                end
                m_pend[k] = irq_in || (m_pend[k] && !take);
            end
        end
    endtask

    initial begin
        bit mie_r;
        irq_cause[0] = 32'h8000_0007;
        irq_cause[1] = 32'h8000_000B;
        for (int k = 0; k < 2; k++) begin
            m_exc[k] = 0; m_redir[k] = 0; m_halt[k] = 0; m_pend[k] = 0;
            m_epc[k] = 0; m_cause[k] = 0; m_rpc[k] = 0;
        end
        rst = 1; in_valid = 0; in_pc = 0; is_ecall = 0; is_ebreak = 0; is_mret = 0;
        is_illegal = 0; irq = 0; mstatus_mie = 0; redirect_ready = 0; mtvec = 0; mepc = 0;
        @(posedge clk);

        // Reset.
        apply(1, 0, 0, 0, 0, 0, 0, 0, 0);
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Ecall, redirect stalled for three cycles.
        apply(0, 1, 32'h8000_0010, 1, 0, 0, 0, 32'h8000_1000, 0);
        for (int i = 0; i < 4; i++) apply(0, 1, 32'h8000_0014, 0, 0, 0, 0, 32'h8000_1000, 0);
        apply(0, 0, 0, 0, 0, 0, 1, 32'h8000_1000, 0);

        // Mret.
        apply(0, 1, 32'h8000_1000, 3, 0, 0, 0, 32'h8000_1000, 32'h8000_0014);
        apply(0, 0, 0, 0, 0, 0, 1, 32'h8000_1000, 32'h8000_0014);
        apply(0, 1, 32'h8000_0014, 0, 0, 0, 0, 0, 0);

        // Interrupt masked, then taken at the next instruction boundary once enabled.
        apply(0, 0, 0, 0, 1, 0, 0, 32'h8000_1000, 0);
        for (int i = 0; i < 5; i++)
            apply(0, 1, 32'h8000_0020 + 32'(i * 4), 0, 0, 0, 0, 32'h8000_1000, 0);
        apply(0, 0, 0, 0, 0, 1, 0, 32'h8000_1000, 0);
        apply(0, 1, 32'h8000_0040, 0, 0, 1, 0, 32'h8000_1000, 0);
        for (int i = 0; i < 3; i++) apply(0, 1, 32'h8000_0044, 0, 0, 1, 1, 32'h8000_1000, 0);

        // Ebreak: halts dut_h, traps with cause 3 on dut_t; illegal; back-to-back plain.
        apply(0, 1, 32'h8000_0050, 2, 0, 0, 0, 32'h8000_2000, 0);
        for (int i = 0; i < 3; i++) apply(0, 1, 32'h8000_0054, 0, 0, 0, 1, 32'h8000_2000, 0);
        apply(0, 1, 32'h8000_0058, 4, 0, 0, 0, 32'h8000_3000, 0);
        for (int i = 0; i < 3; i++) apply(0, 1, 32'h8000_005C, 0, 0, 0, 1, 32'h8000_3000, 0);
        for (int i = 0; i < 4; i++)
            apply(0, 1, 32'h8000_0060 + 32'(i * 4), 0, 0, 0, 1, 0, 0);
        apply(1, 1, 0, 0, 0, 0, 0, 0, 0);
        apply(0, 1, 32'h8000_0070, 0, 0, 0, 0, 0, 0);

        // Reset during redirect drops the redirect and the pending interrupt.
        apply(0, 0, 0, 0, 1, 0, 0, 0, 0);
        apply(0, 1, 32'h8000_0080, 3, 0, 0, 0, 0, 32'h8000_0100);
        apply(1, 0, 0, 0, 0, 0, 0, 0, 0);
        apply(0, 1, 32'h8000_0084, 0, 0, 1, 0, 0, 0);

        // Randomized traffic.
        mie_r = 0;
        for (int i = 0; i < 4000; i++) begin
            int sel, kind;
            sel = $urandom_range(0, 19);
            kind = (sel >= 14 && sel <= 17) ? sel - 13 : 0;
            if ($urandom_range(0, 9) == 0) mie_r = ~mie_r;
            apply($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 6, $urandom & 32'hFFFF_FFFC,
                  kind, $urandom_range(0, 19) == 0, mie_r, $urandom_range(0, 1) == 1,
                  $urandom, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
